// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension units: extension-mode type and encodings.
package imm_ext_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t MODE_SIGN  = 2'b00;
    localparam ext_mode_t MODE_ZERO  = 2'b01;
    localparam ext_mode_t MODE_UPPER = 2'b10;
    localparam ext_mode_t MODE_BOFS  = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (Inst, Mode) -> OUT_W-bit operand.
// Shared by the pipelined wrapper and the single-cycle datapath.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  Inst,
    input  ext_mode_t        Mode,
    output logic [OUT_W-1:0] ExtImm
);

    logic [OUT_W-1:0] sign_s;
    logic [OUT_W-1:0] zero_s;

    // Casts keep IN_W == OUT_W legal, where an explicit zero-width pad would not be.
    assign sign_s = OUT_W'(signed'(Inst));
    assign zero_s = OUT_W'(Inst);

    // Mode select
    always_comb begin
        ExtImm = '0;
        case (Mode)
            MODE_SIGN:  ExtImm = sign_s;
            MODE_ZERO:  ExtImm = zero_s;
            MODE_UPPER: ExtImm = zero_s << (OUT_W - IN_W);
            MODE_BOFS:  ExtImm = sign_s << 2'd2;
            default:    ExtImm = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with valid/ready on both sides and a one-entry skid buffer.
// Optional retire counter (port Ext_Count) is built when IMM_EXT_PERF_CNT_EN is defined.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [IN_W-1:0]  Inst,
    input  ext_mode_t        Mode,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [OUT_W-1:0] ExtImm
`ifdef IMM_EXT_PERF_CNT_EN
    ,
    output logic [31:0]      Ext_Count
`endif
);

    if (IN_W < 2 || IN_W > OUT_W) begin : g_bad_width
        $error("imm_extend_pipe: need 2 <= IN_W <= OUT_W");
    end

    logic [OUT_W-1:0] ext_s;
    logic             accept_s;
    logic             retire_s;

    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic             skid_valid_r;
    logic [OUT_W-1:0] skid_data_r;

    logic             nxt_out_valid_s;
    logic [OUT_W-1:0] nxt_out_data_s;
    logic             nxt_skid_valid_s;
    logic [OUT_W-1:0] nxt_skid_data_s;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .Inst   (Inst),
        .Mode   (Mode),
        .ExtImm (ext_s)
    );

    // Ready depends only on skid state, so Out_Ready never reaches In_Ready combinationally.
    assign In_Ready  = ~skid_valid_r;
    assign accept_s  = In_Valid & ~skid_valid_r;
    assign retire_s  = out_valid_r & Out_Ready;
    assign Out_Valid = out_valid_r;
    assign ExtImm    = out_data_r;

    // Next-state for the two-entry FIFO (output register + skid)
    always_comb begin
        nxt_out_valid_s  = out_valid_r;
        nxt_out_data_s   = out_data_r;
        nxt_skid_valid_s = skid_valid_r;
        nxt_skid_data_s  = skid_data_r;
        if (retire_s && skid_valid_r) begin
            // No accept can coincide here: In_Ready is low while the skid is full.
            nxt_out_data_s   = skid_data_r;
            nxt_skid_valid_s = 1'b0;
        end else if (accept_s && (!out_valid_r || retire_s)) begin
            nxt_out_valid_s = 1'b1;
            nxt_out_data_s  = ext_s;
        end else if (accept_s) begin
            nxt_skid_valid_s = 1'b1;
            nxt_skid_data_s  = ext_s;
        end else if (retire_s) begin
            nxt_out_valid_s = 1'b0;
        end else begin
            nxt_out_valid_s = out_valid_r;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
        end else begin
            out_valid_r  <= nxt_out_valid_s;
            out_data_r   <= nxt_out_data_s;
            skid_valid_r <= nxt_skid_valid_s;
            skid_data_r  <= nxt_skid_data_s;
        end
    end

`ifdef IMM_EXT_PERF_CNT_EN
    logic [31:0] ext_count_r;

    // Wrapping retire counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ext_count_r <= 32'd0;
        end else if (retire_s) begin
            ext_count_r <= ext_count_r + 32'd1;
        end else begin
            ext_count_r <= ext_count_r;
        end
    end

    assign Ext_Count = ext_count_r;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized self-checking bench for imm_extend_pipe (16/32 main instance, 8/16 second instance).
module tb_imm_extend_pipe;

    logic        clk_s = 1'b0;
    logic        rst_n_s = 1'b0;
    logic        in_valid_s = 1'b0;
    logic        in_ready_s;
    logic [15:0] inst_s = 16'd0;
    logic [1:0]  mode_s = 2'd0;
    logic        out_valid_s;
    logic        out_ready_s = 1'b0;
    logic [31:0] ext_imm_s;

    logic        in_valid2_s = 1'b0;
    logic        in_ready2_s;
    logic [7:0]  inst2_s = 8'd0;
    logic [1:0]  mode2_s = 2'd0;
    logic        out_valid2_s;
    logic        out_ready2_s = 1'b1;
    logic [15:0] ext_imm2_s;

`ifdef IMM_EXT_PERF_CNT_EN
    logic [31:0] ext_count_s;
    logic [31:0] ext_count2_s;
`endif

    int total_r = 0;
    int bad_r   = 0;
    longint exp_q[$];
    int retires_r = 0;

    always #5 clk_s = ~clk_s;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .CLK       (clk_s),
        .RST       (rst_n_s),
        .In_Valid  (in_valid_s),
        .In_Ready  (in_ready_s),
        .Inst      (inst_s),
        .Mode      (mode_s),
        .Out_Valid (out_valid_s),
        .Out_Ready (out_ready_s),
        .ExtImm    (ext_imm_s)
`ifdef IMM_EXT_PERF_CNT_EN
        ,
        .Ext_Count (ext_count_s)
`endif
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) u_dut2 (
        .CLK       (clk_s),
        .RST       (rst_n_s),
        .In_Valid  (in_valid2_s),
        .In_Ready  (in_ready2_s),
        .Inst      (inst2_s),
        .Mode      (mode2_s),
        .Out_Valid (out_valid2_s),
        .Out_Ready (out_ready2_s),
        .ExtImm    (ext_imm2_s)
`ifdef IMM_EXT_PERF_CNT_EN
        ,
        .Ext_Count (ext_count2_s)
`endif
    );

    // Reference: treat the immediate as a number, apply the mode arithmetically, reduce mod 2^out_w.
    function automatic longint ref_ext(input int in_w, input int out_w, input longint inst, input int mode);
        longint half;
        longint s;
        longint m;
        longint r;
        half = 64'sd1 << (in_w - 1);
        s    = (inst >= half) ? inst - 2 * half : inst;
        m    = 64'sd1 << out_w;
        case (mode)
            0:       r = s;
            1:       r = inst;
            2:       r = inst * (64'sd1 << (out_w - in_w));
            3:       r = s * 4;
            default: r = 0;
        endcase
        return ((r % m) + m) % m;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total_r++;
        if (act !== exp) begin
            bad_r++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock of the main instance: drive, compare against the queue model at negedge, update model.
    task automatic cycle(input logic v, input logic [15:0] inst, input logic [1:0] mode, input logic ordy);
        logic acc;
        logic ret;
        in_valid_s  = v;
        inst_s      = inst;
        mode_s      = mode;
        out_ready_s = ordy;
        @(negedge clk_s);
        check("in_ready", 64'(in_ready_s), (exp_q.size() < 2) ? 64'd1 : 64'd0);
        check("out_valid", 64'(out_valid_s), (exp_q.size() > 0) ? 64'd1 : 64'd0);
        if (exp_q.size() > 0) check("ext_imm", 64'(ext_imm_s), exp_q[0]);
`ifdef IMM_EXT_PERF_CNT_EN
        check("ext_count", 64'(ext_count_s), 64'(retires_r));
`endif
        acc = v && (exp_q.size() < 2);
        ret = ordy && (exp_q.size() > 0);
        if (ret) begin
            void'(exp_q.pop_front());
            retires_r++;
        end
        if (acc) exp_q.push_back(ref_ext(16, 32, longint'(inst), int'(mode)));
        @(posedge clk_s);
        #1;
    endtask

    initial begin
        #12;
        check("rst_out_valid", 64'(out_valid_s), 64'd0);
        check("rst_in_ready", 64'(in_ready_s), 64'd1);
        check("rst_ext_imm", 64'(ext_imm_s), 64'd0);
        @(negedge clk_s);
        rst_n_s = 1'b1;
        @(posedge clk_s);
        #1;

        // Directed extension cases
        cycle(1'b1, 16'h8004, 2'b00, 1'b1);
        check("t1_sign", 64'(ext_imm_s), 64'hFFFF8004);
        cycle(1'b1, 16'h8004, 2'b01, 1'b1);
        check("t1_zero", 64'(ext_imm_s), 64'h00008004);
        cycle(1'b1, 16'h1234, 2'b10, 1'b1);
        check("t2_upper", 64'(ext_imm_s), 64'h12340000);
        cycle(1'b1, 16'hFFFF, 2'b11, 1'b1);
        check("t2_bofs_neg", 64'(ext_imm_s), 64'hFFFFFFFC);
        cycle(1'b1, 16'h0001, 2'b11, 1'b1);
        check("t2_bofs_pos", 64'(ext_imm_s), 64'h00000004);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);

        // Backpressure
        cycle(1'b1, 16'h0001, 2'b00, 1'b0);
        cycle(1'b1, 16'h0002, 2'b00, 1'b0);
        check("t3_ready_low", 64'(in_ready_s), 64'd0);
        check("t3_hold_a", 64'(ext_imm_s), 64'h00000001);
        cycle(1'b1, 16'h7777, 2'b01, 1'b0);
        check("t3_still_a", 64'(ext_imm_s), 64'h00000001);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);
        check("t3_b_next", 64'(ext_imm_s), 64'h00000002);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);
        check("t3_ready_back", 64'(in_ready_s), 64'd1);
        check("t3_drained", 64'(out_valid_s), 64'd0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'($urandom), 2'($urandom), 1'b1);
            check("t4_stream_ready", 64'(in_ready_s), 64'd1);
        end
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 16'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset with two items in flight
        cycle(1'b1, 16'h1111, 2'b00, 1'b0);
        cycle(1'b1, 16'h2222, 2'b00, 1'b0);
        in_valid_s = 1'b0;
        #2;
        rst_n_s = 1'b0;
        #1;
        check("t5_rst_out_valid", 64'(out_valid_s), 64'd0);
        check("t5_rst_in_ready", 64'(in_ready_s), 64'd1);
        check("t5_rst_ext_imm", 64'(ext_imm_s), 64'd0);
        exp_q.delete();
        retires_r = 0;
        @(negedge clk_s);
        rst_n_s = 1'b1;
        @(posedge clk_s);
        #1;
        cycle(1'b1, 16'h00F0, 2'b01, 1'b1);
        check("t5_clean_first", 64'(ext_imm_s), 64'h000000F0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);
        check("t5_no_stale", 64'(out_valid_s), 64'd0);

        // Five retires then a stall: counter model is checked every cycle
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 2'($urandom), 1'b1);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);
        cycle(1'b1, 16'h0005, 2'b00, 1'b0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1);

        // Second configuration, 8 -> 16 bits, one item at a time
        inst2_s     = 8'h80;
        mode2_s     = 2'b00;
        in_valid2_s = 1'b1;
        @(posedge clk_s);
        #1;
        in_valid2_s = 1'b0;
        check("t6_w8_valid", 64'(out_valid2_s), 64'd1);
        check("t6_w8_sign", 64'(ext_imm2_s), 64'hFF80);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v8;
            logic [1:0] m2;
            v8 = 8'($urandom);
            m2 = 2'($urandom);
            @(posedge clk_s);
            #1;
            inst2_s     = v8;
            mode2_s     = m2;
            in_valid2_s = 1'b1;
            @(posedge clk_s);
            #1;
            in_valid2_s = 1'b0;
            check("t6_w8_valid", 64'(out_valid2_s), 64'd1);
            check("t6_w8_rand", 64'(ext_imm2_s), ref_ext(8, 16, longint'(v8), int'(m2)));
        end

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule
